// File: rtl/mdu_pkg.sv
// Shared op codes, FSM states and width-derived constants for the iterative MDU.
package mdu_pkg;

    localparam int MDU_MAX_W = 128;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_MADD  = 3'd2,
        OP_MADDU = 3'd3,
        OP_DIV   = 3'd4,
        OP_DIVU  = 3'd5,
        OP_MTHI  = 3'd6,
        OP_MTLO  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_e;

    // Callers truncate the result to their own WIDTH.
    function automatic logic [MDU_MAX_W-1:0] mdu_all_ones(input int w);
        return (MDU_MAX_W'(1) << w) - MDU_MAX_W'(1);
    endfunction

    function automatic logic [MDU_MAX_W-1:0] mdu_int_min(input int w);
        return MDU_MAX_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: MSB-first shift-add multiply or restoring divide step.
// The divide path exists only when MDU_DIV_EN is defined.
module mdu_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
`ifdef MDU_DIV_EN
    input  logic               i_div,
    output logic               o_qbit,
`endif
    input  logic [2*WIDTH-2:0] i_acc,
    input  logic [WIDTH-1:0]   i_opnd,
    input  logic               i_bit,
    output logic [2*WIDTH-1:0] o_acc
);

    logic [2*WIDTH-1:0] w_mul;

    assign w_mul = {i_acc, 1'b0} + (i_bit ? {{WIDTH{1'b0}}, i_opnd} : '0);

`ifdef MDU_DIV_EN
    logic [WIDTH:0] w_trial;
    logic [WIDTH:0] w_diff;
    logic           w_ge;

    // Remainder lives in the low bits of the accumulator; the next dividend bit shifts in.
    assign w_trial = {i_acc[WIDTH-1:0], i_bit};
    assign w_diff  = w_trial - {1'b0, i_opnd};
    assign w_ge    = w_trial >= {1'b0, i_opnd};
    assign o_qbit  = i_div & w_ge;
    assign o_acc   = i_div ? {{(WIDTH-1){1'b0}}, (w_ge ? w_diff : w_trial)} : w_mul;
`else
    assign o_acc   = w_mul;
`endif

endmodule

// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit owning HI/LO; one radix-2 step per cycle.
// Define MDU_DIV_EN to build the divider; otherwise DIV/DIVU pulse illegal_op.
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero,
    output logic             illegal_op
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] INT_MIN = WIDTH'(mdu_int_min(WIDTH));

    state_e             r_state;
    state_e             w_state_nxt;
    op_e                w_op;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] w_step_acc;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_sum;
    logic [WIDTH-1:0]   r_bits;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   w_abs_rs;
    logic [WIDTH-1:0]   w_abs_rt;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;
    logic               r_neg;
    logic               r_madd;
    logic               r_done;
    logic               r_ill;
    logic               w_qbit;
    logic               w_is_mt;
    logic               w_is_div;
    logic               w_signed;
    logic               w_sa;
    logic               w_sb;
    logic               w_div_ok;
    logic               w_launch;

    assign w_op     = op_e'(op);
    assign w_is_mt  = (w_op == OP_MTHI) || (w_op == OP_MTLO);
    assign w_is_div = (w_op == OP_DIV) || (w_op == OP_DIVU);
    assign w_signed = w_op inside {OP_MULT, OP_MADD, OP_DIV};
    assign w_sa     = w_signed && ((rs_val & INT_MIN) != '0);
    assign w_sb     = w_signed && ((rt_val & INT_MIN) != '0);
    // -INT_MIN wraps to INT_MIN, which is still the correct unsigned magnitude.
    assign w_abs_rs = w_sa ? -rs_val : rs_val;
    assign w_abs_rt = w_sb ? -rt_val : rt_val;

`ifdef MDU_DIV_EN
    assign w_div_ok = 1'b1;
`else
    assign w_div_ok = !w_is_div;
`endif

    assign w_launch = (r_state == IDLE) && start && !w_is_mt && w_div_ok;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_launch) w_state_nxt = CALC;
            CALC:    if (r_cnt == CNT_W'(WIDTH - 1)) w_state_nxt = FIX;
            FIX:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

`ifdef MDU_DIV_EN
    localparam logic [WIDTH-1:0] ALL_ONES = WIDTH'(mdu_all_ones(WIDTH));
    logic r_div;
    logic r_rem_neg;
    logic r_dbz;
`endif

    mdu_step #(.WIDTH(WIDTH)) u_step (
`ifdef MDU_DIV_EN
        .i_div  (r_div),
        .o_qbit (w_qbit),
`endif
        .i_acc  (r_acc[2*WIDTH-2:0]),
        .i_opnd (r_opnd),
        .i_bit  (r_bits[WIDTH-1]),
        .o_acc  (w_step_acc)
    );

`ifndef MDU_DIV_EN
    assign w_qbit = 1'b0;
`endif

    assign w_prod = r_neg ? -r_acc : r_acc;
    assign w_sum  = r_madd ? {r_hi, r_lo} + w_prod : w_prod;

    always_comb begin
        {w_res_hi, w_res_lo} = w_sum;
`ifdef MDU_DIV_EN
        if (r_div) begin
            // A zero divisor leaves the dividend in the remainder and all ones in the quotient.
            w_res_hi = r_rem_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
            w_res_lo = (r_opnd == '0) ? ALL_ONES : (r_neg ? -r_bits : r_bits);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (w_launch) begin
            r_acc  <= '0;
            r_bits <= w_is_div ? w_abs_rs : w_abs_rt;
            r_opnd <= w_is_div ? w_abs_rt : w_abs_rs;
            r_neg  <= w_sa ^ w_sb;
            r_madd <= (w_op == OP_MADD) || (w_op == OP_MADDU);
`ifdef MDU_DIV_EN
            r_div     <= w_is_div;
            r_rem_neg <= w_sa;
`endif
        end else if (r_state == CALC) begin
            r_acc  <= w_step_acc;
            r_bits <= {r_bits[WIDTH-2:0], w_qbit};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
            r_ill  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_done <= 1'b0;
            r_ill  <= (r_state == IDLE) && start && !w_div_ok;
            if ((r_state == IDLE) && start && w_is_mt) begin
                if (w_op == OP_MTHI) r_hi <= rs_val;
                else                 r_lo <= rs_val;
                r_done <= 1'b1;
            end
            if (w_launch)               r_cnt <= '0;
            else if (r_state == CALC)   r_cnt <= r_cnt + CNT_W'(1);
            if (r_state == FIX) begin
                r_hi   <= w_res_hi;
                r_lo   <= w_res_lo;
                r_done <= 1'b1;
            end
        end
    end

`ifdef MDU_DIV_EN
    always_ff @(posedge clk) begin
        if (rst)                                    r_dbz <= 1'b0;
        else if ((r_state == IDLE) && start)        r_dbz <= 1'b0;
        else if ((r_state == FIX) && r_div && (r_opnd == '0)) r_dbz <= 1'b1;
    end
    assign div_by_zero = r_dbz;
`else
    assign div_by_zero = 1'b0;
`endif

    assign busy       = (r_state != IDLE);
    assign done       = r_done;
    assign illegal_op = r_ill;
    assign hi         = r_hi;
    assign lo         = r_lo;

endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative: directed cases plus random ops against an arithmetic model.
module tb_mdu_iterative;

    localparam int W   = 32;
    localparam int LAT = W + 2;
`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    localparam logic [W-1:0] ONES = {W{1'b1}};
    localparam logic [W-1:0] IMIN = {1'b1, {(W-1){1'b0}}};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] rs_val = '0;
    logic [W-1:0] rt_val = '0;
    logic         busy, done, div_by_zero, illegal_op;
    logic [W-1:0] hi, lo;

    mdu_iterative #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero),
        .illegal_op  (illegal_op)
    );

    // kind: 0 = HI/LO move, 1 = iterative op, 2 = illegal op
    typedef struct {
        int           kind;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           t0;
    } exp_t;

    exp_t         sbq[$];
    exp_t         me;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic on the architectural HI/LO pair.
    task automatic predict(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                           output int kind, output logic dbz);
        logic [2*W-1:0] p;
        kind = 1;
        dbz  = 1'b0;
        case (o)
            3'd0, 3'd2: p = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
            3'd1, 3'd3: p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            default:    p = '0;
        endcase
        case (o)
            3'd0, 3'd1: {m_hi, m_lo} = p;
            3'd2, 3'd3: {m_hi, m_lo} = {m_hi, m_lo} + p;
            3'd4, 3'd5: begin
                if (!DIV_EN) begin
                    kind = 2;
                end else if (b == '0) begin
                    m_hi = a;
                    m_lo = ONES;
                    dbz  = 1'b1;
                end else if (o == 3'd4 && a == IMIN && b == ONES) begin
                    m_hi = '0;
                    m_lo = IMIN;
                end else if (o == 3'd4) begin
                    m_lo = $signed(a) / $signed(b);
                    m_hi = $signed(a) % $signed(b);
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            3'd6: begin m_hi = a; kind = 0; end
            default: begin m_lo = a; kind = 0; end
        endcase
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   g = 0;
        @(negedge clk);
        while (busy && g < 4 * LAT) begin
            @(negedge clk);
            g++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL issue_wait: busy=%0b after %0d cycles, required 0", busy, g);
        end
        predict(o, a, b, e.kind, e.dbz);
        e.hi = m_hi;
        e.lo = m_lo;
        e.t0 = cyc + 1;
        sbq.push_back(e);
        op = o; rs_val = a; rt_val = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // A start while busy must be dropped, so nothing is pushed.
    task automatic poke(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        if (busy) begin
            op = o; rs_val = a; rt_val = b; start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 1;
            2:       return ONES;
            3:       return IMIN;
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst && (done || illegal_op)) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: done=%0b illegal_op=%0b, required no event", done, illegal_op);
            end else begin
                me = sbq.pop_front();
                chk("done_flag", done, me.kind != 2);
                chk("illegal_flag", illegal_op, me.kind == 2);
                chk("hi", hi, me.hi);
                chk("lo", lo, me.lo);
                chk("latency", cyc - me.t0 + 1, (me.kind == 1) ? LAT : 1);
                chk("busy_at_event", busy, 0);
                if (me.kind == 1) chk("div_by_zero", div_by_zero, me.dbz);
            end
        end
    end

    initial begin
        int g;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", div_by_zero, 0);
        chk("rst_illegal", illegal_op, 0);

        issue(3'd0, 32'd3, 32'hFFFFFFFE);
        issue(3'd1, 32'hFFFFFFFF, 32'd2);
        issue(3'd7, 32'd5, 32'd0);
        issue(3'd6, 32'd0, 32'd0);
        issue(3'd2, 32'd3, 32'd4);
        issue(3'd6, 32'd0, 32'd0);
        issue(3'd7, 32'hFFFFFFFF, 32'd0);
        issue(3'd3, 32'd1, 32'd1);
        issue(3'd4, 32'hFFFFFFF9, 32'd2);
        issue(3'd5, 32'd7, 32'd0);
        repeat (LAT + 2) @(negedge clk);
        chk("dbz_sticky", div_by_zero, DIV_EN);
        issue(3'd0, 32'd2, 32'd3);
        issue(3'd4, IMIN, ONES);
        issue(3'd4, IMIN, 32'd0);
        issue(3'd4, 32'd7, 32'hFFFFFFFE);

        issue(3'd0, 32'd1234, 32'hFFFFFFFB);
        repeat (3) @(negedge clk);
        poke(3'd1, ONES, ONES);
        issue(3'd1, 32'd7, 32'd9);
        issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);

        issue(DIV_EN ? 3'd4 : 3'd0, 32'd100, 32'd7);
        repeat (8) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        sbq.delete();
        m_hi = '0;
        m_lo = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        chk("abort_busy", busy, 0);
        repeat (LAT + 4) @(negedge clk);

        for (int i = 0; i < 60; i++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick());
            if ($urandom_range(0, 3) == 0) poke(3'($urandom_range(0, 7)), pick(), pick());
        end

        g = 0;
        while (sbq.size() != 0 && g < 4 * LAT) begin
            @(negedge clk);
            g++;
        end
        chk("drain_outstanding", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
